ring_router_demux_multi: RTL and testbench

//   Parametrised ring demultiplexer for the debug interconnect. Takes the ring ingress dii_flit stream.

---
 rtl/dii_package.sv | 19 +
 rtl/dii_skid_buffer.sv | 39 +++
 rtl/ring_router_demux_multi.sv | 95 +++++++++
 tb/tb_ring_router_demux_multi.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dii_package.sv
// dii_package: debug interconnect flit type, id width and destination helper.
package dii_package;
    localparam int DII_ID_W = 16;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

    typedef enum logic {
        IDLE,
        WORM
    } worm_state_t;

    function automatic logic [DII_ID_W-1:0] dii_dest(input logic [15:0] data);
        return data[DII_ID_W-1:0];
    endfunction
endpackage

// File: rtl/dii_skid_buffer.sv
// dii_skid_buffer: 2-entry FIFO of dii_flit whose ingress ready comes straight from a register.
module dii_skid_buffer
    import dii_package::*;
(
    input  logic    clk,
    input  logic    rst,
    input  dii_flit in_flit,
    output logic    in_ready,
    output dii_flit out_flit,
    input  logic    out_ready
);
    logic [16:0] mem [2];
    logic        rd, wr;
    logic [1:0]  cnt, cnt_n;
    logic        push, pop;

    assign push     = in_flit.valid & in_ready;
    assign pop      = out_ready & (cnt != 2'd0);
    assign cnt_n    = cnt + {1'b0, push} - {1'b0, pop};
    assign out_flit = '{valid: cnt != 2'd0, last: mem[rd][16], data: mem[rd][15:0]};

    // ready is computed from the next occupancy so it is a pure flop output
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            in_ready <= cnt_n != 2'd2;
            if (push) begin
                mem[wr] <= {in_flit.last, in_flit.data};
                wr      <= ~wr;
            end
            if (pop) rd <= ~rd;
        end
    end
endmodule

// File: rtl/ring_router_demux_multi.sv
// ring_router_demux_multi: steers ring worms to NUM_LOCAL local ports or back to the ring.
// Define DII_DEMUX_STATS_EN to add saturating per-port worm counters on stat_worms.
module ring_router_demux_multi
    import dii_package::*;
#(
    parameter int NUM_LOCAL = 1
`ifdef DII_DEMUX_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DII_ID_W-1:0]     id_base,
    input  dii_flit                 in_ring,
    output logic                    in_ring_ready,
    output dii_flit [NUM_LOCAL-1:0] out_local,
    input  logic [NUM_LOCAL-1:0]    out_local_ready,
    output dii_flit                 out_ring,
    input  logic                    out_ring_ready
`ifdef DII_DEMUX_STATS_EN
    , output logic [STAT_W*(NUM_LOCAL+1)-1:0] stat_worms
`endif
);
    localparam int SEL_W = NUM_LOCAL > 1 ? $clog2(NUM_LOCAL) : 1;

    dii_flit            head;
    logic               pop;
    worm_state_t        state, state_n;
    logic [DII_ID_W:0]  off;
    logic               hdr_local, lat_local, cur_local;
    logic [SEL_W-1:0]   hdr_sel, lat_sel, cur_sel;
    logic [NUM_LOCAL-1:0] hit;

    dii_skid_buffer u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_ring),
        .in_ready (in_ring_ready),
        .out_flit (head),
        .out_ready(pop)
    );

    // 17-bit difference: ids below id_base land far above NUM_LOCAL, so no wrap-around
    assign off       = {1'b0, dii_dest(head.data)} - {1'b0, id_base};
    assign hdr_local = off < (DII_ID_W+1)'(NUM_LOCAL);
    assign hdr_sel   = off[SEL_W-1:0];
    assign cur_local = state == WORM ? lat_local : hdr_local;
    assign cur_sel   = state == WORM ? lat_sel : hdr_sel;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_LOCAL; k++) hit[k] = cur_local && cur_sel == SEL_W'(k);
    end

    assign pop = head.valid && (cur_local ? |(hit & out_local_ready) : out_ring_ready);

    for (genvar k = 0; k < NUM_LOCAL; k++) begin : g_out
        assign out_local[k] = '{valid: head.valid & hit[k], last: head.last, data: head.data};
    end
    assign out_ring = '{valid: head.valid & ~cur_local, last: head.last, data: head.data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_local <= 1'b0;
            lat_sel   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && pop) begin
                lat_local <= hdr_local;
                lat_sel   <= hdr_sel;
            end
        end
    end

    always_comb begin
        state_n = state;
        if (pop) state_n = head.last ? IDLE : WORM;
    end

`ifdef DII_DEMUX_STATS_EN
    logic [NUM_LOCAL:0] done;

    assign done = (pop && head.last) ? {~cur_local, hit} : '0;

    for (genvar k = 0; k <= NUM_LOCAL; k++) begin : g_stat
        logic [STAT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) cnt <= '0;
            else if (done[k] && cnt != '1) cnt <= cnt + 1'b1;
        end
        assign stat_worms[k*STAT_W +: STAT_W] = cnt;
    end
`endif
endmodule

// File: tb/tb_ring_router_demux_multi.sv
// tb_ring_router_demux_multi: directed tests of worm routing, back-pressure, id_base changes and reset.
module tb_ring_router_demux_multi;
    import dii_package::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   id_base;
    dii_flit       in_ring;
    logic          in_ring_ready;
    dii_flit [3:0] out_local;
    logic [3:0]    out_local_ready;
    dii_flit       out_ring;
    logic          out_ring_ready;
    logic [4:0]    vmask;
    logic [20:0]   log_q [$];
    int            lv_cycles = 0;
    int            multi_cnt = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

`ifdef DII_DEMUX_STATS_EN
    logic [79:0]   stat_worms;
    logic [9:0]    sat_worms;
    logic          sat_ready;
    dii_flit [3:0] sat_local;
    dii_flit       sat_ring;

    ring_router_demux_multi #(.NUM_LOCAL(4)) dut (
        .clk(clk), .rst(rst), .id_base(id_base), .in_ring(in_ring), .in_ring_ready(in_ring_ready),
        .out_local(out_local), .out_local_ready(out_local_ready), .out_ring(out_ring),
        .out_ring_ready(out_ring_ready), .stat_worms(stat_worms)
    );

    ring_router_demux_multi #(.NUM_LOCAL(4), .STAT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_base(id_base), .in_ring(in_ring), .in_ring_ready(sat_ready),
        .out_local(sat_local), .out_local_ready(out_local_ready), .out_ring(sat_ring),
        .out_ring_ready(out_ring_ready), .stat_worms(sat_worms)
    );
`else
    ring_router_demux_multi #(.NUM_LOCAL(4)) dut (
        .clk(clk), .rst(rst), .id_base(id_base), .in_ring(in_ring), .in_ring_ready(in_ring_ready),
        .out_local(out_local), .out_local_ready(out_local_ready), .out_ring(out_ring),
        .out_ring_ready(out_ring_ready)
    );
`endif

    assign vmask = {out_ring.valid, out_local[3].valid, out_local[2].valid, out_local[1].valid, out_local[0].valid};

    function automatic logic [20:0] ent(input logic [3:0] p, input logic l, input logic [15:0] d);
        return {p, l, d};
    endfunction

    // inputs only change just after posedge, so valid & ready at negedge is a transfer at the next edge
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            if (out_local[k].valid && out_local_ready[k])
                log_q.push_back(ent(4'(k), out_local[k].last, out_local[k].data));
        if (out_ring.valid && out_ring_ready) log_q.push_back(ent(4'hF, out_ring.last, out_ring.data));
        if (|vmask[3:0]) lv_cycles <= lv_cycles + 1;
        if ($countones(vmask) > 1) multi_cnt <= multi_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // call just after a posedge; returns just after the edge that accepted the flit
    task automatic drive_flit(input logic [15:0] d, input logic l);
        int w = 0;
        in_ring = '{valid: 1'b1, last: l, data: d};
        while (1) begin
            @(negedge clk);
            if (in_ring_ready === 1'b1) break;
            w++;
            if (w > 50) begin
                n_chk++; n_fail++;
                $display("FAIL drive_timeout: in_ring_ready=%b required 1", in_ring_ready);
                break;
            end
            @(posedge clk);
        end
        @(posedge clk);
        #1 in_ring.valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        id_base = 16'h0010;
        in_ring = '0;
        out_local_ready = 4'hF;
        out_ring_ready = 1'b1;
        tick(2);
        @(negedge clk);
        n_chk++;
        if (in_ring_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", in_ring_ready); end
        n_chk++;
        if (vmask !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 00000", vmask); end
        tick(1);
        rst = 1'b0;
        tick(1);
        @(negedge clk);
        n_chk++;
        if (in_ring_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", in_ring_ready); end
        tick(1);
    endtask

    task automatic test_local_route();
        int base = log_q.size();
        logic [20:0] ex [$];
        drive_flit(16'h0012, 1'b0);
        @(negedge clk);
        n_chk++;
        if (out_local[2].valid !== 1'b1 || out_local[2].data !== 16'h0012) begin
            n_fail++; $display("FAIL latency: port2 valid=%b data=%h required 1/0012", out_local[2].valid, out_local[2].data);
        end
        n_chk++;
        if (vmask !== 5'b00100) begin n_fail++; $display("FAIL one_hot: got %b required 00100", vmask); end
        tick(1);
        drive_flit(16'hA001, 1'b0);
        drive_flit(16'hA002, 1'b1);
        tick(4);
        ex = '{ent(4'd2, 1'b0, 16'h0012), ent(4'd2, 1'b0, 16'hA001), ent(4'd2, 1'b1, 16'hA002)};
        n_chk++;
        if (log_q.size() - base !== ex.size()) begin n_fail++; $display("FAIL local_count: got %0d required %0d", log_q.size() - base, ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_chk++;
            if (base + i >= log_q.size() || log_q[base+i] !== ex[i]) begin
                n_fail++; $display("FAIL local_flit%0d: got %h required %h", i, (base + i < log_q.size()) ? log_q[base+i] : 21'h0, ex[i]);
            end
        end
    endtask

    task automatic test_ring_route();
        int base = log_q.size();
        int lv0 = lv_cycles;
        logic [20:0] ex [$];
        drive_flit(16'h0014, 1'b0);
        drive_flit(16'hB0B0, 1'b1);
        drive_flit(16'h000F, 1'b1);
        tick(4);
        ex = '{ent(4'hF, 1'b0, 16'h0014), ent(4'hF, 1'b1, 16'hB0B0), ent(4'hF, 1'b1, 16'h000F)};
        n_chk++;
        if (log_q.size() - base !== ex.size()) begin n_fail++; $display("FAIL ring_count: got %0d required %0d", log_q.size() - base, ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_chk++;
            if (base + i >= log_q.size() || log_q[base+i] !== ex[i]) begin
                n_fail++; $display("FAIL ring_flit%0d: got %h required %h", i, (base + i < log_q.size()) ? log_q[base+i] : 21'h0, ex[i]);
            end
        end
        n_chk++;
        if (lv_cycles - lv0 !== 0) begin n_fail++; $display("FAIL ring_local_valid: got %0d cycles required 0", lv_cycles - lv0); end
    endtask

    task automatic test_backpressure();
        int base = log_q.size();
        logic [20:0] ex [$];
        out_local_ready = 4'b1101;
        drive_flit(16'h0011, 1'b0);
        drive_flit(16'hB001, 1'b0);
        @(negedge clk);
        n_chk++;
        if (in_ring_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b required 0", in_ring_ready); end
        n_chk++;
        if (vmask !== 5'b00010 || out_local[1].data !== 16'h0011) begin
            n_fail++; $display("FAIL stall_head: valid=%b data=%h required 00010/0011", vmask, out_local[1].data);
        end
        tick(3);
        out_local_ready = 4'hF;
        drive_flit(16'hB002, 1'b0);
        drive_flit(16'hB003, 1'b1);
        tick(5);
        ex = '{ent(4'd1, 1'b0, 16'h0011), ent(4'd1, 1'b0, 16'hB001), ent(4'd1, 1'b0, 16'hB002), ent(4'd1, 1'b1, 16'hB003)};
        n_chk++;
        if (log_q.size() - base !== ex.size()) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", log_q.size() - base, ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_chk++;
            if (base + i >= log_q.size() || log_q[base+i] !== ex[i]) begin
                n_fail++; $display("FAIL bp_flit%0d: got %h required %h", i, (base + i < log_q.size()) ? log_q[base+i] : 21'h0, ex[i]);
            end
        end
    endtask

    task automatic test_id_base_change();
        int base = log_q.size();
        logic [20:0] ex [$];
        id_base = 16'h0010;
        drive_flit(16'h0011, 1'b0);
        @(posedge clk);
        #1 id_base = 16'h0020;
        drive_flit(16'hC001, 1'b0);
        drive_flit(16'hC002, 1'b1);
        drive_flit(16'h0021, 1'b1);
        drive_flit(16'h0011, 1'b1);
        tick(4);
        ex = '{ent(4'd1, 1'b0, 16'h0011), ent(4'd1, 1'b0, 16'hC001), ent(4'd1, 1'b1, 16'hC002),
               ent(4'd1, 1'b1, 16'h0021), ent(4'hF, 1'b1, 16'h0011)};
        n_chk++;
        if (log_q.size() - base !== ex.size()) begin n_fail++; $display("FAIL idb_count: got %0d required %0d", log_q.size() - base, ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_chk++;
            if (base + i >= log_q.size() || log_q[base+i] !== ex[i]) begin
                n_fail++; $display("FAIL idb_flit%0d: got %h required %h", i, (base + i < log_q.size()) ? log_q[base+i] : 21'h0, ex[i]);
            end
        end
        id_base = 16'h0010;
    endtask

    task automatic test_reset_mid_worm();
        int base;
        logic [20:0] ex [$];
        drive_flit(16'h0013, 1'b0);
        drive_flit(16'hD001, 1'b0);
        tick(2);
        out_local_ready = 4'b0111;
        drive_flit(16'hD002, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(2);
        @(negedge clk);
        n_chk++;
        if (in_ring_ready !== 1'b0 || vmask !== 5'b0) begin
            n_fail++; $display("FAIL mid_reset: ready=%b valid=%b required 0/00000", in_ring_ready, vmask);
        end
        tick(1);
        rst = 1'b0;
        out_local_ready = 4'hF;
        base = log_q.size();
        drive_flit(16'h0010, 1'b1);
        drive_flit(16'h0030, 1'b1);
        tick(4);
        ex = '{ent(4'd0, 1'b1, 16'h0010), ent(4'hF, 1'b1, 16'h0030)};
        n_chk++;
        if (log_q.size() - base !== ex.size()) begin n_fail++; $display("FAIL rst_count: got %0d required %0d", log_q.size() - base, ex.size()); end
        for (int i = 0; i < ex.size(); i++) begin
            n_chk++;
            if (base + i >= log_q.size() || log_q[base+i] !== ex[i]) begin
                n_fail++; $display("FAIL rst_flit%0d: got %h required %h", i, (base + i < log_q.size()) ? log_q[base+i] : 21'h0, ex[i]);
            end
        end
    endtask

`ifdef DII_DEMUX_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        repeat (3) begin
            drive_flit(16'h0010, 1'b0);
            drive_flit(16'hE000, 1'b1);
        end
        drive_flit(16'h0030, 1'b1);
        tick(4);
        n_chk++;
        if (stat_worms[15:0] !== 16'd3) begin n_fail++; $display("FAIL stat_port0: got %0d required 3", stat_worms[15:0]); end
        n_chk++;
        if (stat_worms[79:64] !== 16'd1) begin n_fail++; $display("FAIL stat_ring: got %0d required 1", stat_worms[79:64]); end
        n_chk++;
        if (stat_worms[63:16] !== 48'd0) begin n_fail++; $display("FAIL stat_other: got %h required 0", stat_worms[63:16]); end
        repeat (2) begin
            drive_flit(16'h0010, 1'b0);
            drive_flit(16'hE001, 1'b1);
        end
        tick(4);
        n_chk++;
        if (stat_worms[15:0] !== 16'd5) begin n_fail++; $display("FAIL stat_port0_5: got %0d required 5", stat_worms[15:0]); end
        n_chk++;
        if (sat_worms[1:0] !== 2'd3) begin n_fail++; $display("FAIL stat_saturate: got %0d required 3", sat_worms[1:0]); end
        n_chk++;
        if (sat_worms[9:8] !== 2'd1) begin n_fail++; $display("FAIL stat_sat_ring: got %0d required 1", sat_worms[9:8]); end
    endtask
`endif

    initial begin
        test_reset();
        test_local_route();
        test_ring_route();
        test_backpressure();
        test_id_base_change();
        test_reset_mid_worm();
`ifdef DII_DEMUX_STATS_EN
        test_stats();
`endif
        n_chk++;
        if (multi_cnt !== 0) begin n_fail++; $display("FAIL multi_valid: got %0d cycles required 0", multi_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
